// File: rtl/sram_xlat_arbiter.sv
// sram_xlat_arbiter: round-robin arbiter of NUM_CH request channels onto one synchronous SRAM port,
// with kseg0/kseg1 address translation, misalignment flagging and single-outstanding response routing.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid/addr/wen/wdata  per-channel request (wen==0 is a read)
//   req_ready          one-hot accept for the granted channel
//   resp_valid/err/rdata      per-channel response, one cycle after accept
//   sram_en/wen/addr/wdata    shared SRAM command (physical address)
//   sram_uncached      current access targets kseg1
//   sram_rdata         SRAM read data, valid the cycle after sram_en
module sram_xlat_arbiter #(
   parameter int NUM_CH      = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ENABLE_XLAT = 1
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [NUM_CH-1:0]                  req_valid,
   input  logic [NUM_CH*32-1:0]               req_addr,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]   req_wen,
   input  logic [NUM_CH*DATA_WIDTH-1:0]       req_wdata,
   output logic [NUM_CH-1:0]                  req_ready,
   output logic [NUM_CH-1:0]                  resp_valid,
   output logic [NUM_CH-1:0]                  resp_err,
   output logic [NUM_CH*DATA_WIDTH-1:0]       resp_rdata,
   output logic                               sram_en,
   output logic [DATA_WIDTH/8-1:0]            sram_wen,
   output logic [31:0]                        sram_addr,
   output logic [DATA_WIDTH-1:0]              sram_wdata,
   output logic                               sram_uncached,
   input  logic [DATA_WIDTH-1:0]              sram_rdata
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW = $clog2(SW);

   logic [CW-1:0]         r_rr_ptr;
   logic                  r_pend_valid;
   logic [CW-1:0]         r_pend_ch;
   logic                  r_pend_wr;
   logic                  r_pend_err;

   logic [NUM_CH-1:0]     w_rot;
   logic                  w_any;
   logic                  w_act;
   int                    w_off;
   logic [CW-1:0]         w_gnt;
   logic [CW-1:0]         w_nxt;
   logic [31:0]           w_vaddr;
   logic [SW-1:0]         w_wen;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_mis;
   logic                  w_kseg01;

   // Rotating the valid vector by rr_ptr turns the round-robin scan into a fixed lowest-bit search.
   always_comb begin
      w_rot = NUM_CH'({req_valid, req_valid} >> r_rr_ptr);
      w_any = 1'b0;
      w_off = 0;
      for (int j = NUM_CH - 1; j >= 0; j--)
         if (w_rot[j]) begin
            w_any = 1'b1;
            w_off = j;
         end
      // No grant is given while reset is held so every output reads zero.
      w_act = w_any & resetn;
      w_gnt = CW'((int'(r_rr_ptr) + w_off) % NUM_CH);
      w_nxt = CW'((int'(w_gnt) + 1) % NUM_CH);
   end

   always_comb begin
      req_ready = '0;
      w_vaddr   = '0;
      w_wen     = '0;
      w_wdata   = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (w_act && w_gnt == CW'(c)) begin
            req_ready[c] = 1'b1;
            w_vaddr      = req_addr[c*32 +: 32];
            w_wen        = req_wen[c*SW +: SW];
            w_wdata      = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
         end
   end

   always_comb begin
      w_mis         = |w_vaddr[AW-1:0];
      w_kseg01      = (ENABLE_XLAT != 0) && (w_vaddr[31:30] == 2'b10);
      sram_en       = w_act && !w_mis;
      sram_wen      = sram_en ? w_wen : '0;
      sram_addr     = w_kseg01 ? {3'b000, w_vaddr[28:0]} : w_vaddr;
      sram_wdata    = w_wdata;
      sram_uncached = (ENABLE_XLAT != 0) && (w_vaddr[31:29] == 3'b101);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rr_ptr     <= '0;
         r_pend_valid <= 1'b0;
         r_pend_ch    <= '0;
         r_pend_wr    <= 1'b0;
         r_pend_err   <= 1'b0;
      end else begin
         r_pend_valid <= w_act;
         if (w_act) begin
            r_rr_ptr   <= w_nxt;
            r_pend_ch  <= w_gnt;
            r_pend_wr  <= |w_wen;
            r_pend_err <= w_mis;
         end
      end
   end

   always_comb begin
      resp_valid = '0;
      resp_err   = '0;
      resp_rdata = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (r_pend_valid && r_pend_ch == CW'(c)) begin
            resp_valid[c] = 1'b1;
            resp_err[c]   = r_pend_err;
            resp_rdata[c*DATA_WIDTH +: DATA_WIDTH] = (r_pend_wr || r_pend_err) ? '0 : sram_rdata;
         end
   end
endmodule

// File: tb/tb_sram_xlat_arbiter.sv
// tb_sram_xlat_arbiter: directed bench with a per-cycle reference model and literal spot checks.
module tb_sram_xlat_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_addr;
   logic [N*SW-1:0] req_wen;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready, resp_valid, resp_err;
   logic [N*DW-1:0] resp_rdata;
   logic            sram_en, sram_uncached;
   logic [SW-1:0]   sram_wen;
   logic [31:0]     sram_addr;
   logic [DW-1:0]   sram_wdata, sram_rdata;

   logic [N-1:0]    nx_req_ready, nx_resp_valid, nx_resp_err;
   logic [N*DW-1:0] nx_resp_rdata;
   logic            nx_sram_en, nx_sram_uncached;
   logic [SW-1:0]   nx_sram_wen;
   logic [31:0]     nx_sram_addr;
   logic [DW-1:0]   nx_sram_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_xlat_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ENABLE_XLAT(1)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_uncached(sram_uncached), .sram_rdata(sram_rdata));

   sram_xlat_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ENABLE_XLAT(0)) nx (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen),
      .req_wdata(req_wdata), .req_ready(nx_req_ready), .resp_valid(nx_resp_valid), .resp_err(nx_resp_err),
      .resp_rdata(nx_resp_rdata), .sram_en(nx_sram_en), .sram_wen(nx_sram_wen), .sram_addr(nx_sram_addr),
      .sram_wdata(nx_sram_wdata), .sram_uncached(nx_sram_uncached), .sram_rdata(sram_rdata));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: remembers whose turn it is and the single access awaiting its response.
   int          m_rr = 0;
   bit          m_pv = 0;
   int          m_pc = 0;
   bit          m_pwr = 0;
   bit          m_perr = 0;
   int          g;
   logic [31:0] va, pa;
   bit          mis, unc;
   logic [N-1:0]    e_rdy, e_rv, e_re;
   logic [N*DW-1:0] e_rd;
   logic            e_en;
   logic [SW-1:0]   e_wen;
   logic [DW-1:0]   e_wd;

   always @(negedge clk) begin
      if (!resetn) begin
         m_rr = 0;
         m_pv = 0;
         chk("m_rst_ready", req_ready, 0);
         chk("m_rst_resp", resp_valid, 0);
         chk("m_rst_err", resp_err, 0);
         chk("m_rst_rdata", resp_rdata, 0);
         chk("m_rst_en", sram_en, 0);
         chk("m_rst_addr", sram_addr, 0);
      end else begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
         va = 0; mis = 0; unc = 0; e_wen = 0; e_wd = 0;
         if (g >= 0) begin
            va  = req_addr[g*32 +: 32];
            mis = (va % 4) != 0;
            unc = va >= 32'hA000_0000 && va < 32'hC000_0000;
            e_wd = req_wdata[g*DW +: DW];
         end
         pa = (va >= 32'h8000_0000 && va < 32'hA000_0000) ? va - 32'h8000_0000 :
              unc ? va - 32'hA000_0000 : va;
         e_rdy = (g >= 0) ? N'(1 << g) : '0;
         e_en  = g >= 0 && !mis;
         if (e_en) e_wen = req_wen[g*SW +: SW];
         e_rv = m_pv ? N'(1 << m_pc) : '0;
         e_re = (m_pv && m_perr) ? N'(1 << m_pc) : '0;
         e_rd = (m_pv && !m_pwr && !m_perr) ? (64'(sram_rdata) << (m_pc * DW)) : '0;
         chk("m_ready", req_ready, e_rdy);
         chk("m_en", sram_en, e_en);
         chk("m_wen", sram_wen, e_wen);
         chk("m_resp_valid", resp_valid, e_rv);
         chk("m_resp_err", resp_err, e_re);
         chk("m_resp_rdata", resp_rdata, e_rd);
         if (!(g >= 0 && mis)) begin
            chk("m_addr", sram_addr, pa);
            chk("m_wdata", sram_wdata, e_wd);
            chk("m_uncached", sram_uncached, unc);
         end
         if (g >= 0) begin
            m_pv   = 1;
            m_pc   = g;
            m_pwr  = req_wen[g*SW +: SW] != 0;
            m_perr = mis;
            m_rr   = (g + 1) % N;
         end else m_pv = 0;
      end
   end

   initial begin
      resetn = 1'b0; req_valid = '0; req_addr = '0; req_wen = '0; req_wdata = '0; sram_rdata = '0;
      step();
      req_valid = 2'b11; req_addr = {32'h8000_0000, 32'h0000_0000}; #2;
      chk("rst_ready", req_ready, 0);
      chk("rst_en", sram_en, 0);
      chk("rst_resp", resp_valid, 0);
      step();
      resetn = 1'b1; req_valid = '0;
      step();
      // kseg1 read on ch1
      req_valid = 2'b10; req_addr = {32'hBFC0_0000, 32'h0}; req_wen = '0; #2;
      chk("k1_ready", req_ready, 2'b10);
      chk("k1_en", sram_en, 1);
      chk("k1_addr", sram_addr, 32'h1FC0_0000);
      chk("k1_unc", sram_uncached, 1);
      chk("nx_addr", nx_sram_addr, 32'hBFC0_0000);
      chk("nx_unc", nx_sram_uncached, 0);
      step();
      req_valid = '0; sram_rdata = 32'h3C1D_BFC0; #2;
      chk("k1_resp", resp_valid, 2'b10);
      chk("k1_rdata1", resp_rdata[63:32], 32'h3C1D_BFC0);
      chk("k1_rdata0", resp_rdata[31:0], 0);
      chk("k1_err", resp_err, 0);
      step();
      // round robin under contention
      for (int i = 0; i < 6; i++) begin
         req_valid = 2'b11;
         req_addr  = {32'h8000_0200 + 32'(i * 16), 32'h0000_0100 + 32'(i * 16)};
         req_wen   = {4'h3, 4'h0};
         req_wdata = {32'hA500_0000 + 32'(i), 32'h5A00_0000 + 32'(i)};
         sram_rdata = 32'h0000_1000 + 32'(i);
         #2;
         chk("rr_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
         chk("rr_resp", resp_valid, (i == 0) ? 2'b00 : ((i % 2) ? 2'b01 : 2'b10));
         step();
      end
      req_valid = '0; req_wen = '0; #2;
      chk("rr_last_resp", resp_valid, 2'b10);
      step();
      // kseg0 write on ch0
      req_valid = 2'b01; req_addr = {32'h0, 32'h8000_1000}; req_wen = {4'h0, 4'hF};
      req_wdata = {32'h0, 32'hDEAD_BEEF}; #2;
      chk("k0_addr", sram_addr, 32'h0000_1000);
      chk("k0_wen", sram_wen, 4'hF);
      chk("k0_unc", sram_uncached, 0);
      chk("k0_wdata", sram_wdata, 32'hDEAD_BEEF);
      step();
      req_valid = '0; req_wen = '0; sram_rdata = 32'h1234_5678; #2;
      chk("k0_resp", resp_valid, 2'b01);
      chk("k0_rdata", resp_rdata[31:0], 0);
      step();
      // misaligned read
      req_valid = 2'b01; req_addr = {32'h0, 32'h8000_0002}; #2;
      chk("mis_ready", req_ready, 2'b01);
      chk("mis_en", sram_en, 0);
      chk("mis_wen", sram_wen, 0);
      step();
      req_valid = '0; sram_rdata = 32'hCAFE_F00D; #2;
      chk("mis_resp", resp_valid, 2'b01);
      chk("mis_err", resp_err, 2'b01);
      chk("mis_rdata", resp_rdata[31:0], 0);
      step();
      // pass-through and segment boundaries
      req_valid = 2'b01; req_addr = {32'hC000_0000, 32'h0040_0000}; #2;
      chk("pt_useg", sram_addr, 32'h0040_0000);
      chk("pt_useg_unc", sram_uncached, 0);
      step();
      req_valid = 2'b10; #2;
      chk("pt_k3", sram_addr, 32'hC000_0000);
      chk("pt_k3_unc", sram_uncached, 0);
      step();
      req_valid = 2'b01; req_addr = {32'h0, 32'h9FFF_FFFC}; #2;
      chk("b_k0top", sram_addr, 32'h1FFF_FFFC);
      chk("b_k0top_unc", sram_uncached, 0);
      step();
      req_addr = {32'h0, 32'hA000_0000}; #2;
      chk("b_k1base", sram_addr, 32'h0000_0000);
      chk("b_k1base_unc", sram_uncached, 1);
      chk("b_k1base_en", sram_en, 1);
      step();
      req_addr = {32'h0, 32'h7FFF_FFFC}; #2;
      chk("b_usegtop", sram_addr, 32'h7FFF_FFFC);
      step();
      req_valid = '0;
      step();
      // reset with an access in flight
      req_valid = 2'b10; req_addr = {32'hA000_0010, 32'h0}; #2;
      chk("ro_ready1", req_ready, 2'b10);
      step();
      req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0020}; sram_rdata = 32'h0000_0077; #2;
      chk("ro_resp1", resp_valid, 2'b10);
      chk("ro_ready0", req_ready, 2'b01);
      step();
      resetn = 1'b0; #2;
      chk("ro_drop", resp_valid, 0);
      step();
      req_valid = 2'b11; #2;
      chk("ro_hold_ready", req_ready, 0);
      chk("ro_hold_resp", resp_valid, 0);
      step();
      resetn = 1'b1; #2;
      chk("ro_first_gnt", req_ready, 2'b01);
      chk("ro_no_stale", resp_valid, 0);
      step();
      req_valid = '0; #2;
      chk("ro_new_resp", resp_valid, 2'b01);
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
